bbc_cycle_seq: RTL



---
 rtl/bbc_cycle_seq_if.sv | 21 ++
 rtl/bbc_cycle_seq.sv | 137 +++++++++++++
 2 files changed

// File: rtl/bbc_cycle_seq_if.sv
// CPU-side request/acknowledge bundle for the host bus-cycle sequencer.
// Handshake: the master raises cpu_req with cpu_rnw/cpu_wdata stable and holds it until a
// one-cycle cpu_ack; cpu_err and rd_data are valid with that ack, and req drops on the next edge.
interface bbc_cycle_seq_if;
  logic       cpu_req;
  logic       cpu_rnw;
  logic [7:0] cpu_wdata;
  logic       cpu_ack;
  logic       cpu_err;
  logic [7:0] rd_data;

  modport master (
    output cpu_req, cpu_rnw, cpu_wdata,
    input  cpu_ack, cpu_err, rd_data
  );

  modport slave (
    input  cpu_req, cpu_rnw, cpu_wdata,
    output cpu_ack, cpu_err, rd_data
  );
endinterface

// File: rtl/bbc_cycle_seq.sv
// Host bus-cycle sequencer: aligns CPU requests to the BBC 2MHz phi0, stretches slow
// (1MHz) accesses, and snoops writes to the paged-ROM and shadow select registers.
module bbc_cycle_seq #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              hsclk,
  input  logic              resetb,
  input  logic              bbc_phi0,
  bbc_cycle_seq_if.slave    cpu,
  input  logic              dec_rom_reg,
  input  logic              dec_shadow_reg,
  input  logic              dec_fe4x,
  input  logic [7:0]        bbc_rdata,
  output logic              lat_en,
  output logic              bbc_cyc,
  output logic              bbc_data_oe,
  output logic [3:0]        rom_sel,
  output logic              shadow_en,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ALIGN  = 2'd1;
  localparam logic [1:0] BUS_HI = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0] state;
  logic [2:0] sync;
  logic       ph1m;
  logic [7:0] tcnt;
  logic       fc;
  logic       rnw_q;
  logic       slow_q;
  logic       rom_q;
  logic       shd_q;
  logic       err_q;
  logic [3:0] wdata_lo;
  logic       wdata_b7;
  logic [7:0] rd_q;
  logic [3:0] rom_sel_q;
  logic       shadow_q;
  logic       rise;
  logic       fall;

  // Only the ROM number and the shadow bit of the write data are ever consumed.
  logic unused_wdata;
  assign unused_wdata = ^cpu.cpu_wdata[6:4];

  assign rise = sync[1] & ~sync[2];
  assign fall = ~sync[1] & sync[2];

  always_ff @(posedge hsclk or negedge resetb) begin
    if (!resetb) begin
      state     <= IDLE;
      sync      <= 3'b000;
      ph1m      <= 1'b0;
      tcnt      <= 8'd0;
      fc        <= 1'b0;
      rnw_q     <= 1'b0;
      slow_q    <= 1'b0;
      rom_q     <= 1'b0;
      shd_q     <= 1'b0;
      err_q     <= 1'b0;
      wdata_lo  <= 4'd0;
      wdata_b7  <= 1'b0;
      rd_q      <= 8'd0;
      rom_sel_q <= 4'd0;
      shadow_q  <= 1'b0;
    end else begin
      sync <= {sync[1:0], bbc_phi0};
      if (rise) ph1m <= ~ph1m;

      case (state)
        IDLE: begin
          if (cpu.cpu_req) begin
            rnw_q    <= cpu.cpu_rnw;
            wdata_lo <= cpu.cpu_wdata[3:0];
            wdata_b7 <= cpu.cpu_wdata[7];
            slow_q   <= dec_fe4x;
            rom_q    <= dec_rom_reg;
            shd_q    <= dec_shadow_reg;
            err_q    <= 1'b0;
            tcnt     <= 8'd0;
            state    <= ALIGN;
          end
        end

        ALIGN: begin
          // A slow access may only start on the phi0 rise that begins a 1MHz period.
          if (rise && (!slow_q || !ph1m)) begin
            fc    <= 1'b0;
            state <= BUS_HI;
          end else if (!rise && (tcnt >= TMO_LAST)) begin
            err_q <= 1'b1;
            state <= DONE;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end

        BUS_HI: begin
          if (fall) begin
            if (fc == slow_q) begin
              if (rnw_q) rd_q <= bbc_rdata;
              state <= DONE;
            end else begin
              fc <= fc + 1'b1;
            end
          end
        end

        DONE: begin
          if (!err_q && !rnw_q) begin
            if (rom_q) rom_sel_q <= wdata_lo;
            if (shd_q) shadow_q  <= wdata_b7;
          end
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign lat_en       = (state == ALIGN) || (state == BUS_HI);
  assign bbc_cyc      = (state == BUS_HI);
  assign bbc_data_oe  = (state == BUS_HI) && !rnw_q;
  assign cpu.cpu_ack  = (state == DONE);
  assign cpu.cpu_err  = (state == DONE) && err_q;
  assign cpu.rd_data  = rd_q;
  assign rom_sel      = rom_sel_q;
  assign shadow_en    = shadow_q;
  assign dbg_state    = state;

endmodule
